// File: rtl/ble_pkg.sv
// Shared BLE definitions: RX de-whitener FSM states, whitening LFSR geometry,
// packet-format constants and the LFSR next-state function (also used by TX).
package ble_pkg;

  localparam int unsigned LFSR_W        = 7;
  localparam int unsigned DWH_POLY_TAP  = 4;
  localparam int unsigned BLE_CRC_BYTES = 3;
  localparam int unsigned BLE_MAX_LEN   = 255;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR0    = 3'd1,
    S_HDR1    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CRC     = 3'd4,
    S_DONE    = 3'd5
  } rx_dwh_state_t;

  // x^7+x^4+1: rotate left, the feedback bit also folds into the tap position.
  function automatic logic [LFSR_W-1:0] dwh_lfsr_next(input logic [LFSR_W-1:0] c);
    logic [LFSR_W-1:0] n;
    n               = {c[LFSR_W-2:0], c[LFSR_W-1]};
    n[DWH_POLY_TAP] = c[DWH_POLY_TAP-1] ^ c[LFSR_W-1];
    return n;
  endfunction

endpackage

// File: rtl/ble_bit2byte.sv
// Serial-to-byte packer: LSB-first shift register with 3-bit bit counter.
// byte_cmpl/byte_nxt expose the completing byte combinationally so the
// parent FSM can act on the same edge that registers rx_byte.
module ble_bit2byte (
  input  logic       pka_1or2m_gclk,
  input  logic       r_rx_rst_n,
  input  logic       clr,
  input  logic       bit_vld,
  input  logic       bit_in,
  output logic       byte_cmpl,
  output logic [7:0] byte_nxt,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld
);

  logic [2:0] bit_cnt;
  logic [7:0] shreg;

  assign byte_nxt  = {bit_in, shreg[7:1]};
  assign byte_cmpl = bit_vld && (bit_cnt == 3'd7);

  // Shift bits in, emit a one-cycle byte strobe on every eighth bit.
  always_ff @(posedge pka_1or2m_gclk or negedge r_rx_rst_n) begin
    if (!r_rx_rst_n) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_byte     <= '0;
      rx_byte_vld <= 1'b0;
    end else if (clr) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_byte_vld <= 1'b0;
    end else begin
      rx_byte_vld <= 1'b0;
      if (bit_vld) begin
        shreg   <= byte_nxt;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_cmpl) begin
        rx_byte     <= byte_nxt;
        rx_byte_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ble_rx_dewhitener.sv
// BLE RX de-whitener: x^7+x^4+1 de-whitening of the post-access-address bit
// stream, byte packing, PDU length capture and payload/CRC byte accounting.
// Optional macro BLE_RX_DWH_BYPASS_EN adds dwh_bypass for unwhitened DTM
// packets (bits pass through, LFSR holds).
module ble_rx_dewhitener
  import ble_pkg::*;
#(
  parameter int unsigned MAX_LEN   = BLE_MAX_LEN,
  parameter int unsigned CRC_BYTES = BLE_CRC_BYTES
) (
  input  logic              pka_1or2m_gclk,
  input  logic              r_rx_rst_n,
  input  logic              fsm_dwh_init,
  input  logic              fsm_switch_dwh,
  input  logic              vld_data_rx,
  input  logic              r_data,
  input  logic [LFSR_W-1:0] ble_dwh_init,
`ifdef BLE_RX_DWH_BYPASS_EN
  input  logic              dwh_bypass,
`endif
  output logic [LFSR_W-1:0] r_dwh_lfsr,
  output logic              s_data,
  output logic              s_data_vld,
  output logic [7:0]        rx_byte,
  output logic              rx_byte_vld,
  output logic [7:0]        pdu_len,
  output logic              pdu_len_vld,
  output logic              rx_done,
  output logic              len_err
);

  rx_dwh_state_t state;
  logic [7:0]    byte_cnt;
  logic          consume_st;
  logic          bit_step;
  logic          bypass_on;
  logic          dwh_bit;
  logic          byte_cmpl;
  logic [7:0]    byte_nxt;
  logic          len_over;
  logic          pay_last;
  logic          crc_last;

`ifdef BLE_RX_DWH_BYPASS_EN
  assign bypass_on = dwh_bypass;
`else
  assign bypass_on = 1'b0;
`endif

  assign consume_st = (state == S_HDR0) || (state == S_HDR1) ||
                      (state == S_PAYLOAD) || (state == S_CRC);
  assign bit_step   = fsm_switch_dwh && vld_data_rx && consume_st && !fsm_dwh_init;
  assign dwh_bit    = bypass_on ? r_data : (r_dwh_lfsr[LFSR_W-1] ^ r_data);
  assign len_over   = 32'(byte_nxt) > MAX_LEN;
  assign pay_last   = (byte_cnt == pdu_len - 8'd1);
  assign crc_last   = (byte_cnt == 8'(CRC_BYTES - 1));

  // De-whitening bit path: LFSR advance and registered output bit.
  always_ff @(posedge pka_1or2m_gclk or negedge r_rx_rst_n) begin
    if (!r_rx_rst_n) begin
      r_dwh_lfsr <= '0;
      s_data     <= 1'b0;
      s_data_vld <= 1'b0;
    end else if (fsm_dwh_init) begin
      r_dwh_lfsr <= ble_dwh_init;
      s_data_vld <= 1'b0;
    end else begin
      s_data_vld <= bit_step;
      if (bit_step) begin
        s_data <= dwh_bit;
        if (!bypass_on) r_dwh_lfsr <= dwh_lfsr_next(r_dwh_lfsr);
      end
    end
  end

  ble_bit2byte u_bit2byte (
    .pka_1or2m_gclk (pka_1or2m_gclk),
    .r_rx_rst_n     (r_rx_rst_n),
    .clr            (fsm_dwh_init),
    .bit_vld        (bit_step),
    .bit_in         (dwh_bit),
    .byte_cmpl      (byte_cmpl),
    .byte_nxt       (byte_nxt),
    .rx_byte        (rx_byte),
    .rx_byte_vld    (rx_byte_vld)
  );

  // Packet FSM stepped on byte completion (combinational strobe), so status
  // outputs land in the same cycle as the corresponding rx_byte_vld.
  always_ff @(posedge pka_1or2m_gclk or negedge r_rx_rst_n) begin
    if (!r_rx_rst_n) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      pdu_len     <= '0;
      pdu_len_vld <= 1'b0;
      rx_done     <= 1'b0;
      len_err     <= 1'b0;
    end else if (fsm_dwh_init) begin
      state       <= S_HDR0;
      byte_cnt    <= '0;
      pdu_len     <= '0;
      pdu_len_vld <= 1'b0;
      rx_done     <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (byte_cmpl) begin
        unique case (state)
          S_HDR0: state <= S_HDR1;
          S_HDR1: begin
            pdu_len     <= byte_nxt;
            pdu_len_vld <= 1'b1;
            byte_cnt    <= '0;
            if (len_over) begin
              len_err <= 1'b1;
              rx_done <= 1'b1;
              state   <= S_DONE;
            end else if (byte_nxt == 8'd0) begin
              state <= S_CRC;
            end else begin
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (pay_last) begin
              byte_cnt <= '0;
              state    <= S_CRC;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          S_CRC: begin
            if (crc_last) begin
              rx_done <= 1'b1;
              state   <= S_DONE;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ble_rx_dewhitener.sv
// Bench for ble_rx_dewhitener: two instances (MAX_LEN 255 and 37) share the
// stimulus; whitening is modelled as multiply-by-x modulo x^7+x^4+1.
module tb_ble_rx_dewhitener;
  import ble_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, init, sw, vld, rdata;
  logic [6:0] seed;
`ifdef BLE_RX_DWH_BYPASS_EN
  logic       byp;
`endif

  logic [6:0] o0_lfsr, o1_lfsr;
  logic       o0_sd, o0_sdv, o0_bv, o0_plv, o0_done, o0_le;
  logic       o1_sd, o1_sdv, o1_bv, o1_plv, o1_done, o1_le;
  logic [7:0] o0_byte, o0_pl, o1_byte, o1_pl;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ble_rx_dewhitener #(.MAX_LEN(255), .CRC_BYTES(3)) dut0 (
    .pka_1or2m_gclk(clk), .r_rx_rst_n(rst_n), .fsm_dwh_init(init),
    .fsm_switch_dwh(sw), .vld_data_rx(vld), .r_data(rdata), .ble_dwh_init(seed),
`ifdef BLE_RX_DWH_BYPASS_EN
    .dwh_bypass(byp),
`endif
    .r_dwh_lfsr(o0_lfsr), .s_data(o0_sd), .s_data_vld(o0_sdv),
    .rx_byte(o0_byte), .rx_byte_vld(o0_bv), .pdu_len(o0_pl),
    .pdu_len_vld(o0_plv), .rx_done(o0_done), .len_err(o0_le));

  ble_rx_dewhitener #(.MAX_LEN(37), .CRC_BYTES(3)) dut1 (
    .pka_1or2m_gclk(clk), .r_rx_rst_n(rst_n), .fsm_dwh_init(init),
    .fsm_switch_dwh(sw), .vld_data_rx(vld), .r_data(rdata), .ble_dwh_init(seed),
`ifdef BLE_RX_DWH_BYPASS_EN
    .dwh_bypass(byp),
`endif
    .r_dwh_lfsr(o1_lfsr), .s_data(o1_sd), .s_data_vld(o1_sdv),
    .rx_byte(o1_byte), .rx_byte_vld(o1_bv), .pdu_len(o1_pl),
    .pdu_len_vld(o1_plv), .rx_done(o1_done), .len_err(o1_le));

  // Monitor state, owned by the sampling block below.
  logic [7:0] q0[$], q1[$];
  logic       sq0[$], sq1[$];
  int         done0, done1, dat0, dat1, gap_sdv;
  logic       mon_clr = 1'b0;
  logic       gap_flag = 1'b0;
  logic [7:0] pkt[$];

  // Sample DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (mon_clr) begin
      q0.delete(); q1.delete(); sq0.delete(); sq1.delete();
      done0 = 0; done1 = 0; dat0 = 0; dat1 = 0; gap_sdv = 0;
    end else begin
      if (o0_bv) q0.push_back(o0_byte);
      if (o1_bv) q1.push_back(o1_byte);
      if (o0_sdv) sq0.push_back(o0_sd);
      if (o1_sdv) sq1.push_back(o1_sd);
      if (o0_done) begin done0++; dat0 = q0.size(); end
      if (o1_done) begin done1++; dat1 = q1.size(); end
      if (gap_flag && (o0_sdv || o1_sdv)) gap_sdv++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whitening sequence as polynomial arithmetic: s <- s*x mod (x^7+x^4+1).
  function automatic logic [6:0] ref_step(input logic [6:0] s);
    logic [7:0] t;
    t = {s, 1'b0};
    if (t[7]) t = t ^ 8'h91;
    return t[6:0];
  endfunction

  function automatic logic [6:0] ref_adv(input logic [6:0] s, input int n);
    logic [6:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = ref_step(r);
    return r;
  endfunction

  task automatic build(input logic [7:0] h0, input logic [7:0] len,
                       input bit ramp, input logic [23:0] crc);
    pkt.delete();
    pkt.push_back(h0);
    pkt.push_back(len);
    for (int i = 0; i < int'(len); i++) pkt.push_back(ramp ? 8'(i) : 8'($urandom));
    pkt.push_back(crc[7:0]);
    pkt.push_back(crc[15:8]);
    pkt.push_back(crc[23:16]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    vld = 1'b1;
    rdata = b;
    tick();
    vld = 1'b0;
    rdata = 1'($urandom);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic do_gap(input logic [6:0] exp_l);
    vld = 1'b0;
    tick();
    sw = 1'b0;
    gap_flag = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vld = ~vld;
      rdata = 1'($urandom);
      tick();
    end
    vld = 1'b0;
    gap_flag = 1'b0;
    check("gap_sdata_vld", gap_sdv, 0);
    check("gap_lfsr", o0_lfsr, exp_l);
    sw = 1'b1;
  endtask

  task automatic run_pkt(input logic [6:0] sd, input bit do_init, input bit byp_on,
                         input int gap_at, input int stop_at);
    logic [6:0] st;
    logic [7:0] cur;
    logic       k;
    mon_clr = 1'b1;
    sw = 1'b1;
    if (do_init) begin
      seed = sd;
      init = 1'b1;
      vld = 1'b1;
      rdata = 1'($urandom);
    end
    tick();
    init = 1'b0;
    vld = 1'b0;
    mon_clr = 1'b0;
    st = sd;
    for (int i = 0; i < pkt.size() * 8; i++) begin
      if (i == stop_at) break;
      if (i == gap_at) do_gap(st);
      k = byp_on ? 1'b0 : st[6];
      if (!byp_on) st = ref_step(st);
      cur = pkt[i / 8];
      send_bit(cur[i % 8] ^ k);
    end
    repeat (4) tick();
  endtask

  task automatic chk_inst(input string nm, input logic [7:0] q[$], input logic sq[$],
                          input int dn, input int dat, input logic [7:0] pl,
                          input logic plv, input logic le, input int unsigned m);
    int unsigned len;
    int          nexp;
    logic [7:0]  cur;
    int          bad;
    len  = pkt[1];
    nexp = (len > m) ? 2 : int'(len) + 5;
    check({nm, " nbytes"}, q.size(), nexp);
    for (int j = 0; j < nexp && j < q.size(); j++)
      check($sformatf("%s byte%0d", nm, j), q[j], pkt[j]);
    check({nm, " nbits"}, sq.size(), nexp * 8);
    bad = 0;
    for (int j = 0; j < nexp * 8 && j < sq.size(); j++) begin
      cur = pkt[j / 8];
      if (sq[j] !== cur[j % 8]) bad++;
    end
    check({nm, " s_data_bad"}, bad, 0);
    check({nm, " done_cnt"}, dn, 1);
    check({nm, " done_at_byte"}, dat, nexp);
    check({nm, " pdu_len"}, pl, len);
    check({nm, " pdu_len_vld"}, plv, 1);
    check({nm, " len_err"}, le, (len > m) ? 1 : 0);
  endtask

  initial begin
    logic [6:0] sd;
    rst_n = 1'b1; init = 1'b0; sw = 1'b0; vld = 1'b0; rdata = 1'b0; seed = '0;
`ifdef BLE_RX_DWH_BYPASS_EN
    byp = 1'b0;
`endif
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("reset_out0", {o0_lfsr, o0_sd, o0_sdv, o0_byte, o0_bv, o0_pl, o0_plv, o0_done, o0_le}, 0);
    check("reset_out1", {o1_lfsr, o1_sd, o1_sdv, o1_byte, o1_bv, o1_pl, o1_plv, o1_done, o1_le}, 0);
    rst_n = 1'b1;
    tick();

    // Zero-length PDU straight into CRC.
    build(8'h02, 8'h00, 1'b0, 24'hABCDEF);
    run_pkt(7'h53, 1'b1, 1'b0, -1, -1);
    chk_inst("t1d0", q0, sq0, done0, dat0, o0_pl, o0_plv, o0_le, 255);
    chk_inst("t1d1", q1, sq1, done1, dat1, o1_pl, o1_plv, o1_le, 37);

    // 37-byte ramp payload.
    build(8'($urandom), 8'd37, 1'b1, 24'($urandom));
    run_pkt(7'h4B, 1'b1, 1'b0, -1, -1);
    chk_inst("t2d0", q0, sq0, done0, dat0, o0_pl, o0_plv, o0_le, 255);
    chk_inst("t2d1", q1, sq1, done1, dat1, o1_pl, o1_plv, o1_le, 37);

    // Length 38: accepted by dut0, rejected by dut1 (MAX_LEN 37).
    sd = 7'($urandom) | 7'h01;
    build(8'($urandom), 8'h26, 1'b0, 24'($urandom));
    run_pkt(sd, 1'b1, 1'b0, -1, -1);
    chk_inst("t3d0", q0, sq0, done0, dat0, o0_pl, o0_plv, o0_le, 255);
    chk_inst("t3d1", q1, sq1, done1, dat1, o1_pl, o1_plv, o1_le, 37);
    check("t3d1 lfsr_frozen", o1_lfsr, ref_adv(sd, 16));

    // De-whitening paused mid-payload.
    sd = 7'($urandom) | 7'h01;
    build(8'($urandom), 8'd20, 1'b0, 24'($urandom));
    run_pkt(sd, 1'b1, 1'b0, 8 * 7 + 3, -1);
    chk_inst("t4d0", q0, sq0, done0, dat0, o0_pl, o0_plv, o0_le, 255);

    // Abort at third payload byte, bit 4; then a full packet with no extra init.
    build(8'($urandom), 8'd10, 1'b0, 24'($urandom));
    run_pkt(7'h25, 1'b1, 1'b0, -1, 36);
    seed = 7'h25;
    init = 1'b1;
    vld = 1'b1;
    rdata = 1'($urandom);
    tick();
    init = 1'b0;
    vld = 1'b0;
    check("abort_state", 32'(dut0.state), 32'(S_HDR0));
    check("abort_lfsr", o0_lfsr, 7'h25);
    check("abort_pdu_len_vld", o0_plv, 0);
    check("abort_no_done", done0, 0);
    run_pkt(7'h25, 1'b0, 1'b0, -1, -1);
    chk_inst("t5d0", q0, sq0, done0, dat0, o0_pl, o0_plv, o0_le, 255);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_out", {o0_lfsr, o0_sd, o0_sdv, o0_byte, o0_bv, o0_pl, o0_plv, o0_done, o0_le}, 0);
    check("async_rst_state", 32'(dut0.state), 32'(S_IDLE));
    #3 rst_n = 1'b1;
    tick();

`ifdef BLE_RX_DWH_BYPASS_EN
    byp = 1'b1;
    build(8'hA5, 8'h00, 1'b0, 24'($urandom));
    run_pkt(7'h3C, 1'b1, 1'b1, -1, -1);
    chk_inst("t6d0", q0, sq0, done0, dat0, o0_pl, o0_plv, o0_le, 255);
    check("bypass_lfsr", o0_lfsr, 7'h3C);
    byp = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
